// File: rtl/counter_event_unit.sv
// rtl/counter_event_unit.sv - edge capture, event counting and interrupt for three counter outputs
// Optional timestamp timer and TSTAMP register built when COUNTER_EVT_TSTAMP_EN is defined.
module counter_event_unit #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        counter0_out,
  input  logic        counter1_out,
  input  logic        counter2_out,
  input  logic        evt_we,
  input  logic [1:0]  evt_addr,
  input  logic [31:0] evt_wdata,
  output logic [31:0] evt_rdata,
  output logic        evt_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       prev_q;
  logic [2:0]       pending_q;
  logic [2:0]       en_q;
  logic [2:0]       mask_q;
  logic [2:0]       pol_q;
  logic [CNT_W-1:0] cnt_q [3];

  logic [2:0] sync_now;
  logic [2:0] edge_hit;
  logic [2:0] qual;
  logic [2:0] w1c;
  logic [2:0] cnt_clr;
  logic       wr_status;
  logic       wr_ctrl;
  logic       wr_count;
  logic       unused_wdata;

  assign sync_now  = sync_q[SYNC_STAGES-1];
  // Polarity only selects which comparison is used, so flipping it never fabricates an edge.
  assign edge_hit  = (pol_q & ~sync_now & prev_q) | (~pol_q & sync_now & ~prev_q);
  assign qual      = edge_hit & en_q;
  assign wr_status = evt_we && (evt_addr == 2'd0);
  assign wr_ctrl   = evt_we && (evt_addr == 2'd1);
  assign wr_count  = evt_we && (evt_addr == 2'd2);
  assign w1c       = wr_status ? evt_wdata[2:0] : 3'b000;
  assign cnt_clr   = wr_count ? evt_wdata[2:0] : 3'b000;

  assign unused_wdata = ^{evt_wdata[31:11], evt_wdata[7], evt_wdata[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 3'b000;
      prev_q    <= 3'b000;
      pending_q <= 3'b000;
      en_q      <= 3'b000;
      mask_q    <= 3'b000;
      pol_q     <= 3'b000;
      evt_irq   <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync_q[0] <= {counter2_out, counter1_out, counter0_out};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q    <= sync_now;
      pending_q <= (pending_q & ~w1c) | qual;
      if (wr_ctrl) begin
        en_q   <= evt_wdata[2:0];
        mask_q <= evt_wdata[6:4];
        pol_q  <= evt_wdata[10:8];
      end
      evt_irq <= |(pending_q & mask_q);
      // A clear coinciding with an edge leaves that edge counted.
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr[i]) begin
          cnt_q[i] <= CNT_W'(qual[i]);
        end else if (qual[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef COUNTER_EVT_TSTAMP_EN
  logic [31:0] timer_q;
  logic [31:0] tstamp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= 32'd0;
      tstamp_q <= 32'd0;
    end else begin
      timer_q <= timer_q + 32'd1;
      if (|qual) tstamp_q <= timer_q;
    end
  end
`endif

  always_comb begin
    evt_rdata = 32'd0;
    case (evt_addr)
      2'd0: evt_rdata[2:0] = pending_q;
      2'd1: begin
        evt_rdata[2:0]  = en_q;
        evt_rdata[6:4]  = mask_q;
        evt_rdata[10:8] = pol_q;
      end
      2'd2: evt_rdata[3*CNT_W-1:0] = {cnt_q[2], cnt_q[1], cnt_q[0]};
      2'd3: begin
`ifdef COUNTER_EVT_TSTAMP_EN
        evt_rdata = tstamp_q;
`endif
      end
      default: evt_rdata = 32'd0;
    endcase
  end

endmodule
